// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and sizing helpers for the matrix-multiply engine.
package matmul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StDone
  } state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Accumulator width: a sum of n products of two dw-bit values cannot overflow it.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
    return 2 * dw + clog2(n);
  endfunction

  // Row-major element index i*n+j.
  function automatic int unsigned rm_idx(input int unsigned i, input int unsigned j,
                                         input int unsigned n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/matmul_engine_if.sv
// matmul_engine_if: load, command, read-back and status signals of the engine.
interface matmul_engine_if
  import matmul_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned RW = 8
);
  localparam int unsigned AddrW = clog2(N * N);

  logic             wr_en;
  logic             wr_sel;
  logic [AddrW-1:0] wr_addr;
  logic [DW-1:0]    wr_data;
  logic             start;
  logic [AddrW:0]   rd_addr;
  logic [RW-1:0]    rd_data;
  logic             busy;
  logic             done;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
    input  rd_data, busy, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
    output rd_data, busy, done
  );

endinterface

// File: rtl/matmul_mac.sv
// matmul_mac: multiplier plus AW-bit accumulator; clr_i ends a dot product.
module matmul_mac #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [AW-1:0] sum_o
);
  logic [2*DW-1:0] prod;
  logic [AW-1:0]   acc_q, acc_d;

  // Running sum including the current product; this is what C receives on the last k.
  always_comb begin
    prod  = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
    sum_o = acc_q + AW'(prod);
    acc_d = acc_q;
    if (en_i) acc_d = clr_i ? '0 : sum_o;
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: loads N x N matrices A and B, computes C = A x B with one MAC per clock,
// and reads C back through a registered port. Define MATMUL_SAT_EN to saturate read-out
// values at 2^RW-1 instead of truncating them.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned RW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  matmul_engine_if.slave bus
);
  localparam int unsigned     Elems  = N * N;
  localparam int unsigned     AddrW  = clog2(Elems);
  localparam int unsigned     CntW   = clog2(N);
  localparam int unsigned     AW     = acc_width(DW, N);
  localparam logic [CntW-1:0] CntMax = CntW'(N - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DW-1:0]    a_q [Elems];
  logic [DW-1:0]    a_d [Elems];
  logic [DW-1:0]    b_q [Elems];
  logic [DW-1:0]    b_d [Elems];
  logic [AW-1:0]    c_q [Elems];
  logic [AW-1:0]    c_d [Elems];
  logic [RW-1:0]    rd_data_q, rd_data_d;
  logic             mac_en, k_last, last_mac, wr_ok, busy, done;
  logic [AddrW-1:0] a_idx, b_idx, c_idx;
  logic [AW-1:0]    mac_sum, rd_val;

  assign mac_en   = (state_q == StMac);
  assign k_last   = (k_q == CntMax);
  assign last_mac = mac_en && k_last && (j_q == CntMax) && (i_q == CntMax);
  assign wr_ok    = (state_q == StIdle) && bus.wr_en && (32'(bus.wr_addr) < Elems);
  assign a_idx    = AddrW'(rm_idx(32'(i_q), 32'(k_q), N));
  assign b_idx    = AddrW'(rm_idx(32'(k_q), 32'(j_q), N));
  assign c_idx    = AddrW'(rm_idx(32'(i_q), 32'(j_q), N));

  matmul_mac #(
    .DW(DW),
    .AW(AW)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (mac_en),
    .clr_i(k_last),
    .a_i  (a_q[a_idx]),
    .b_i  (b_q[b_idx]),
    .sum_o(mac_sum)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StMac;
      StMac:   if (last_mac) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StMac:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Index advance: k fastest, then j, then i; all wrap back to 0 after the last MAC.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (mac_en) begin
      if (k_last) begin
        k_d = '0;
        if (j_q == CntMax) begin
          j_d = '0;
          i_d = (i_q == CntMax) ? '0 : i_q + CntW'(1);
        end else begin
          j_d = j_q + CntW'(1);
        end
      end else begin
        k_d = k_q + CntW'(1);
      end
    end
  end

  // Matrix storage updates: loads only in idle, C written at the end of each dot product.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    if (wr_ok && !bus.wr_sel) a_d[bus.wr_addr] = bus.wr_data;
    if (wr_ok && bus.wr_sel)  b_d[bus.wr_addr] = bus.wr_data;
    if (mac_en && k_last)     c_d[c_idx] = mac_sum;
  end

  // Read-out conversion from AW to RW; out-of-range addresses read 0.
  always_comb begin
    rd_val = '0;
    if (32'(bus.rd_addr) < Elems) rd_val = c_q[AddrW'(bus.rd_addr)];
`ifdef MATMUL_SAT_EN
    rd_data_d = (rd_val > AW'({RW{1'b1}})) ? '1 : RW'(rd_val);
`else
    rd_data_d = RW'(rd_val);
`endif
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      a_q       <= '{default: '0};
      b_q       <= '{default: '0};
      c_q       <= '{default: '0};
      rd_data_q <= '0;
    end else begin
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy;
  assign bus.done    = done;

endmodule
